imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-port 256x128 instruction memory between the instruction fetch unit (read-only requester) and a program loader (read/write requester). It arbitrates per cycle, drives the memory port, and tags returning read data to its owner. A load-lock state machine gives the loader exclusive access for program download and reports the count of words written. The block sits between `ifu`/loader and the `mem_wrapper` instance.

## Interface
- `ADDR_WIDTH`, 8, memory word address width
- `DATA_WIDTH`, 128, memory word width
- `STARVE_MAX`, 4, consecutive IFU wins before the loader is forced (used only with the configuration macro)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ifu_req`  in  1  IFU read request
- `ifu_addr`  in  ADDR_WIDTH  IFU read address
- `ifu_gnt`  out  1  IFU request accepted this cycle
- `ifu_rd_vld`  out  1  IFU read data valid
- `ifu_rd_data`  out  DATA_WIDTH  IFU read data
- `ld_lock`  in  1  loader requests exclusive access
- `ld_vld`  in  1  loader request valid
- `ld_we`  in  1  1 = write, 0 = read-back
- `ld_addr`  in  ADDR_WIDTH  loader address
- `ld_wdata`  in  DATA_WIDTH  loader write data
- `ld_rdy`  out  1  loader request accepted this cycle
- `ld_rd_vld`  out  1  loader read-back data valid
- `ld_rd_data`  out  DATA_WIDTH  loader read-back data
- `ld_done`  out  1  one-cycle pulse at the end of a lock session
- `ld_cnt`  out  ADDR_WIDTH+1  writes accepted in the last/current lock session
- `mem_ce`, `mem_we`  out  1  memory chip enable / write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_din`  out  DATA_WIDTH  memory write data
- `mem_dout`  in  DATA_WIDTH  memory read data, valid one cycle after `mem_ce & ~mem_we`

## Operation
- FSM states: RUN (reset), LOAD.
- RUN to LOAD when `ld_lock`=1; LOAD to RUN when `ld_lock`=0. Transitions take effect on the next clock edge.
- RUN arbitration is combinational from the current requests:
  - Only one requester: that requester wins.
  - Both requesting: the IFU wins.
- LOAD: `ifu_gnt`=0 always. The loader wins whenever `ld_vld`=1.
- Winner drives the memory port: `mem_ce`=1, `mem_addr` = winner address.
  - IFU win: `mem_we`=0.
  - Loader win: `mem_we`=`ld_we` and `mem_din`=`ld_wdata`.
- No winner: `mem_ce`=0, `mem_we`=0.
- `ifu_gnt` = IFU wins; `ld_rdy` = loader wins. A request is accepted on the cycle its grant is high.
- Read ownership is registered: `ifu_rd_vld` <= IFU win; `ld_rd_vld` <= loader win & ~`ld_we`. Both data outputs are `mem_dout` directly, qualified by their valid.
- `ld_cnt`:
  - Cleared on the RUN-to-LOAD edge.
  - +1 per accepted loader write while in LOAD.
  - Saturates at 2^ADDR_WIDTH.
  - Held in RUN.
- `ld_done`=1 for exactly the first RUN cycle after LOAD.

## Timing
- Reset values (registered): state=RUN, `ifu_rd_vld`=0, `ld_rd_vld`=0, `ld_done`=0, `ld_cnt`=0, starve count=0.
- While `rst_n`=0, the combinational outputs `mem_ce`, `mem_we`, `ifu_gnt` and `ld_rdy` are forced to 0.
- Grant latency: 0 cycles. Read data latency: 1 cycle after the grant.
- A read granted in the cycle `ld_lock` rises still returns `ifu_rd_vld`=1 next cycle.
- `ld_lock` falling with `ld_vld`=1 in the same cycle: the loader is still granted. That cycle counts as LOAD.
- Reset mid-session: state returns to RUN with no `ld_done` pulse. Any pending read valid is dropped.
- Back-to-back grants are allowed every cycle. There are no bubbles between requesters.

## Configuration
- `IMEM_ARB_STARVE_EN` defined:
  - In RUN, a counter increments on each IFU win that occurs while `ld_vld`=1.
  - When the count equals `STARVE_MAX` and both requesters are requesting, the loader wins and the count clears.
  - The count clears on any loader win, or in any cycle with `ld_vld`=0.
- `IMEM_ARB_STARVE_EN` not defined: strict IFU priority in RUN, and no counter is instantiated. The loader can starve.

## Test plan
- **Reset:** hold `rst_n`=0 with `ifu_req`=1 and `ld_vld`=1 → `mem_ce`=0, both grants 0, `ld_cnt`=0, `ld_done`=0.
- **IFU read:** `ifu_req`=1, `ifu_addr`=8'h05, memory preloaded → `mem_ce`=1, `mem_we`=0, `mem_addr`=8'h05 the same cycle; `ifu_rd_vld`=1 next cycle with the word at 0x05.
- **Contention:** `ifu_req` and `ld_vld`=1 held for 10 cycles.
  - With the macro and `STARVE_MAX`=4, the grant pattern is IFU×4, LD, IFU×4, LD.
  - Without the macro, the IFU wins all 10 cycles.
- **Lock session:**
  - Stimulus: `ld_lock`=1, then 3 writes to 0x10–0x12 while `ifu_req`=1, then `ld_lock`=0.
  - Response: `ifu_gnt`=0 throughout LOAD; `ld_cnt`=3; `ld_done` pulses once.
  - Follow-up: IFU reads of 0x11 return the written data.
- **Loader read-back in RUN:** `ld_vld`=1, `ld_we`=0, `ld_addr`=8'h11, `ifu_req`=0 → `ld_rdy`=1; `ld_rd_vld`=1 next cycle; `ifu_rd_vld`=0.
- **Reset mid-LOAD:** after 2 writes, assert `rst_n`=0 for one cycle with `ld_lock`=1 → state RUN, `ld_cnt`=0, no `ld_done` pulse. The block re-enters LOAD on the next cycle because `ld_lock` is still 1.

Source files
------------

// File: rtl/imem_arbiter.sv
// Per-cycle arbiter sharing the single-port instruction memory between the IFU and the program loader.
// Optional loader anti-starvation counter is enabled by defining IMEM_ARB_STARVE_EN.
module imem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rd_vld,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,

    input  logic                  ld_lock,
    input  logic                  ld_vld,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_rdy,
    output logic                  ld_rd_vld,
    output logic [DATA_WIDTH-1:0] ld_rd_data,
    output logic                  ld_done,
    output logic [ADDR_WIDTH:0]   ld_cnt,

    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q,      state_d;
    logic                  ifu_rd_vld_q, ifu_rd_vld_d;
    logic                  ld_rd_vld_q,  ld_rd_vld_d;
    logic                  ld_done_q,    ld_done_d;
    logic [ADDR_WIDTH:0]   ld_cnt_q,     ld_cnt_d;

    logic                  ifu_win;
    logic                  ld_win;
    logic                  force_ld;

`ifdef IMEM_ARB_STARVE_EN
    localparam int unsigned          STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_q, starve_d;

    always_comb begin
        force_ld = (state_q == RUN) && ifu_req && ld_vld && (starve_q == STARVE_LIM);
    end

    // Counts IFU wins taken from a waiting loader; any idle loader cycle forgives the debt.
    always_comb begin
        starve_d = starve_q;
        if (!ld_vld || ld_win) begin
            starve_d = '0;
        end else if (ifu_win) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        force_ld = 1'b0;
    end
`endif

    always_comb begin
        ifu_win = 1'b0;
        ld_win  = 1'b0;
        if (rst_n) begin
            if (state_q == LOAD) begin
                ld_win = ld_vld;
            end else begin
                ifu_win = ifu_req && !force_ld;
                ld_win  = ld_vld && (!ifu_req || force_ld);
            end
        end
    end

    always_comb begin
        mem_ce   = ifu_win || ld_win;
        mem_we   = ld_win && ld_we;
        mem_addr = '0;
        mem_din  = '0;
        if (ifu_win) begin
            mem_addr = ifu_addr;
        end else if (ld_win) begin
            mem_addr = ld_addr;
            mem_din  = ld_wdata;
        end
    end

    always_comb begin
        state_d      = ld_lock ? LOAD : RUN;
        ifu_rd_vld_d = ifu_win;
        ld_rd_vld_d  = ld_win && !ld_we;
        ld_done_d    = (state_q == LOAD) && !ld_lock;

        ld_cnt_d = ld_cnt_q;
        if (state_q == RUN) begin
            if (ld_lock) begin
                ld_cnt_d = '0;
            end
        end else if (ld_win && ld_we && (ld_cnt_q != CNT_MAX)) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            ifu_rd_vld_q <= 1'b0;
            ld_rd_vld_q  <= 1'b0;
            ld_done_q    <= 1'b0;
            ld_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ifu_rd_vld_q <= ifu_rd_vld_d;
            ld_rd_vld_q  <= ld_rd_vld_d;
            ld_done_q    <= ld_done_d;
            ld_cnt_q     <= ld_cnt_d;
        end
    end

    always_comb begin
        ifu_gnt     = ifu_win;
        ld_rdy      = ld_win;
        ifu_rd_vld  = ifu_rd_vld_q;
        ld_rd_vld   = ld_rd_vld_q;
        ld_done     = ld_done_q;
        ld_cnt      = ld_cnt_q;
        ifu_rd_data = ifu_rd_vld_q ? mem_dout : '0;
        ld_rd_data  = ld_rd_vld_q  ? mem_dout : '0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter against a cycle-level reference model with its own memory image.
module tb_imem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 128;
    localparam int unsigned SMAX = 4;
`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req;
    logic [AW-1:0] ifu_addr;
    logic          ifu_gnt, ifu_rd_vld;
    logic [DW-1:0] ifu_rd_data;
    logic          ld_lock, ld_vld, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_rdy, ld_rd_vld, ld_done;
    logic [DW-1:0] ld_rd_data;
    logic [AW:0]   ld_cnt;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rd_vld(ifu_rd_vld), .ifu_rd_data(ifu_rd_data),
        .ld_lock(ld_lock), .ld_vld(ld_vld), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdy(ld_rdy), .ld_rd_vld(ld_rd_vld),
        .ld_rd_data(ld_rd_data), .ld_done(ld_done), .ld_cnt(ld_cnt),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory attached to the DUT port.
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) bmem[mem_addr] <= mem_din;
            else        mem_dout <= bmem[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    bit            m_load, m_done, m_ifu_vld, m_ld_vld;
    logic [DW-1:0] m_rdata;
    int            m_cnt, m_starve;
    bit            armed;

    int n_vec = 0;
    int n_bad = 0;
    int g_ifu, g_ld, g_ce, n_done;
    bit last_ifu_gnt;

    localparam logic [DW-1:0] W0 = 128'h0010_0000_DEAD_BEEF_0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] W1 = 128'h0011_1111_CAFE_F00D_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] W2 = 128'h0012_2222_0BAD_C0DE_AAAA_5555_AAAA_5555;

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
        return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare everything against the model, then advance the model.
    task automatic cyc();
        bit e_ifu, e_ld, frc;
        #1;
        e_ifu = 1'b0;
        e_ld  = 1'b0;
        if (rst_n) begin
            if (m_load) begin
                e_ld = ld_vld;
            end else begin
                frc   = STARVE_EN && ifu_req && ld_vld && (m_starve == SMAX);
                e_ifu = ifu_req && !frc;
                e_ld  = ld_vld && (!ifu_req || frc);
            end
        end
        chk("ifu_gnt", 128'(ifu_gnt), 128'(e_ifu));
        chk("ld_rdy",  128'(ld_rdy),  128'(e_ld));
        chk("mem_ce",  128'(mem_ce),  128'(e_ifu | e_ld));
        chk("mem_we",  128'(mem_we),  128'(e_ld & ld_we));
        if (e_ifu) chk("mem_addr_ifu", 128'(mem_addr), 128'(ifu_addr));
        if (e_ld)  chk("mem_addr_ld",  128'(mem_addr), 128'(ld_addr));
        if (e_ld && ld_we) chk("mem_din", mem_din, ld_wdata);
        if (armed) begin
            chk("ifu_rd_vld",  128'(ifu_rd_vld), 128'(m_ifu_vld));
            chk("ld_rd_vld",   128'(ld_rd_vld),  128'(m_ld_vld));
            chk("ifu_rd_data", ifu_rd_data, m_ifu_vld ? m_rdata : '0);
            chk("ld_rd_data",  ld_rd_data,  m_ld_vld  ? m_rdata : '0);
            chk("ld_done",     128'(ld_done),    128'(m_done));
            chk("ld_cnt",      128'(ld_cnt),     128'(m_cnt));
        end
        g_ifu += int'(ifu_gnt);
        g_ld  += int'(ld_rdy);
        g_ce  += int'(mem_ce);
        n_done += int'(ld_done);
        last_ifu_gnt = ifu_gnt;

        if (!rst_n) begin
            m_load = 0; m_done = 0; m_ifu_vld = 0; m_ld_vld = 0;
            m_cnt = 0; m_starve = 0;
        end else begin
            if (e_ifu) m_rdata = ref_mem[ifu_addr];
            else if (e_ld && !ld_we) m_rdata = ref_mem[ld_addr];
            if (e_ld && ld_we) ref_mem[ld_addr] = ld_wdata;
            m_ifu_vld = e_ifu;
            m_ld_vld  = e_ld && !ld_we;
            m_done    = m_load && !ld_lock;
            if (!m_load && ld_lock) m_cnt = 0;
            else if (m_load && e_ld && ld_we && m_cnt < 256) m_cnt++;
            if (!ld_vld || e_ld) m_starve = 0;
            else if (e_ifu) m_starve++;
            m_load = ld_lock;
        end
        armed = 1'b1;
        @(negedge clk);
    endtask

    task automatic drv(input bit r, input bit ir, input logic [AW-1:0] ia,
                       input bit lk, input bit lv, input bit lw,
                       input logic [AW-1:0] la, input logic [DW-1:0] wd);
        rst_n = r; ifu_req = ir; ifu_addr = ia;
        ld_lock = lk; ld_vld = lv; ld_we = lw; ld_addr = la; ld_wdata = wd;
        cyc();
    endtask

    task automatic clr_counts();
        g_ifu = 0; g_ld = 0; g_ce = 0; n_done = 0;
    endtask

    initial begin
        logic [9:0] seq;
        bit lk;
        for (int i = 0; i < 256; i++) begin
            bmem[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        m_rdata = '0; armed = 1'b0;
        m_load = 0; m_done = 0; m_ifu_vld = 0; m_ld_vld = 0; m_cnt = 0; m_starve = 0;
        rst_n = 0; ifu_req = 0; ifu_addr = '0; ld_lock = 0; ld_vld = 0; ld_we = 0;
        ld_addr = '0; ld_wdata = '0;
        @(negedge clk);

        // Reset with both requesters active
        clr_counts();
        for (int i = 0; i < 3; i++) drv(0, 1, 8'h05, 0, 1, 1, 8'h20, '1);
        chk("rst_grants", 128'(g_ifu + g_ld + g_ce), 128'd0);
        chk("rst_cnt",  128'(ld_cnt), 128'd0);
        chk("rst_done", 128'(ld_done), 128'd0);

        // Simple IFU read of 0x05
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        drv(1, 1, 8'h05, 0, 0, 0, 8'h00, '0);
        chk("ifu_read_vld",  128'(ifu_rd_vld), 128'd1);
        chk("ifu_read_data", ifu_rd_data, pat(5));

        // Contention for 10 cycles
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        for (int i = 0; i < 10; i++) begin
            drv(1, 1, 8'(i), 0, 1, 0, 8'(8'h40 + i), '0);
            seq[i] = last_ifu_gnt;
        end
        chk("contention_seq", 128'(seq), STARVE_EN ? 128'h1EF : 128'h3FF);

        // Lock session: 3 writes while the IFU keeps requesting
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        drv(1, 1, 8'h07, 1, 0, 0, 8'h00, '0);
        chk("lock_rise_ifu_vld", 128'(ifu_rd_vld), 128'd1);
        clr_counts();
        drv(1, 1, 8'h07, 1, 1, 1, 8'h10, W0);
        drv(1, 1, 8'h07, 1, 1, 1, 8'h11, W1);
        drv(1, 1, 8'h07, 1, 1, 1, 8'h12, W2);
        drv(1, 1, 8'h07, 0, 0, 0, 8'h00, '0);
        chk("load_ifu_gnt", 128'(g_ifu), 128'd0);
        chk("load_cnt", 128'(ld_cnt), 128'd3);
        drv(1, 1, 8'h11, 0, 0, 0, 8'h00, '0);
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        chk("load_done_pulses", 128'(n_done), 128'd1);
        chk("ifu_read_0x11", ifu_rd_data, 128'h0);
        drv(1, 1, 8'h11, 0, 0, 0, 8'h00, '0);
        chk("ifu_read_0x11_data", ifu_rd_data, W1);

        // Loader read-back in RUN
        drv(1, 0, 8'h00, 0, 1, 0, 8'h11, '0);
        chk("rb_ld_vld",  128'(ld_rd_vld), 128'd1);
        chk("rb_ifu_vld", 128'(ifu_rd_vld), 128'd0);
        chk("rb_data",    ld_rd_data, W1);

        // Reset mid-LOAD
        drv(1, 0, 8'h00, 1, 0, 0, 8'h00, '0);
        drv(1, 0, 8'h00, 1, 1, 1, 8'h30, W0);
        drv(1, 0, 8'h00, 1, 1, 1, 8'h31, W2);
        clr_counts();
        drv(0, 0, 8'h00, 1, 0, 0, 8'h00, '0);
        chk("midrst_cnt",  128'(ld_cnt), 128'd0);
        drv(1, 1, 8'h02, 1, 1, 1, 8'h32, W1);
        chk("midrst_run_ifu", 128'(last_ifu_gnt), 128'd1);
        drv(1, 1, 8'h02, 1, 0, 0, 8'h00, '0);
        chk("midrst_load_ifu", 128'(last_ifu_gnt), 128'd0);
        chk("midrst_no_done", 128'(n_done), 128'd0);
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);

        // Randomised traffic with occasional resets and lock sessions
        lk = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) lk = !lk;
            drv($urandom_range(0, 59) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                lk, 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)),
                {$urandom, $urandom, $urandom, $urandom});
        end

        // Write-count saturation
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        drv(1, 0, 8'h00, 1, 0, 0, 8'h00, '0);
        for (int i = 0; i < 258; i++)
            drv(1, 1, 8'h00, 1, 1, 1, 8'(i), {$urandom, $urandom, $urandom, $urandom});
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        chk("cnt_saturate", 128'(ld_cnt), 128'd256);
        drv(1, 0, 8'h00, 0, 0, 0, 8'h00, '0);
        chk("cnt_hold_run", 128'(ld_cnt), 128'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
